inst_axi_rd_bridge: RTL and testbench

- Sits directly upstream of the fetch stage. It terminates the fetch stage's SRAM-like instruction port (req/addr_ok/data_ok) and converts it into AXI4 read-address (AR) and read-data (R) channel transactions.
- Tracks up to MAX_OUTSTANDING in-flight reads.
- Returns instruction data to the fetch stage in request order.
- Throttles addr_ok so the fetch stage can never over-issue.

---
 rtl/inst_axi_rd_bridge.sv | 143 ++++++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch bridge: converts the fetch stage's SRAM-like request
// port into single-beat AXI4 reads and returns the data in request order.
// A two-state AR machine holds one address at a time on the bus, while a
// small counter tracks how many accepted reads still owe a data beat.
module inst_axi_rd_bridge #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'h0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic        rd_err
);

    typedef enum logic {
        IDLE,
        SEND
    } ar_state_t;

    localparam logic [1:0] CNT_MAX = 2'(MAX_OUTSTANDING);

    ar_state_t   state;
    ar_state_t   state_next;
    logic [1:0]  cnt;
    logic [31:0] araddr_q;
    logic [1:0]  size_q;
    logic        accept;
    logic        consume;
    logic        rd_err_q;

    // Fetch never writes; the flag is part of the port but carries no meaning here.
    logic unused_wr;
    assign unused_wr = inst_sram_wr;

    // AR state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs: accept only in IDLE with a free slot, present AR in SEND.
    always_comb begin
        state_next        = state;
        inst_sram_addr_ok = 1'b0;
        arvalid           = 1'b0;
        case (state)
            IDLE: begin
                inst_sram_addr_ok = inst_sram_req && (cnt < CNT_MAX);
                if (inst_sram_addr_ok) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept  = inst_sram_req && inst_sram_addr_ok;
    assign consume = rvalid && rready;

    // Capture address and size at acceptance; they stay frozen while AR is pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            araddr_q <= 32'h0;
            size_q   <= 2'b00;
        end else if (accept) begin
            araddr_q <= inst_sram_addr;
            size_q   <= inst_sram_size;
        end
    end

    // Outstanding reads: a slot is taken at acceptance and freed when its beat is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 2'd0;
        end else if (accept && !consume) begin
            cnt <= cnt + 2'd1;
        end else if (consume && !accept) begin
            cnt <= cnt - 2'd1;
        end
    end

    // Sticky record of any non-OKAY read response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_err_q <= 1'b0;
        end else if (consume && (rresp != 2'b00)) begin
            rd_err_q <= 1'b1;
        end
    end

    assign arid              = AXI_ID;
    assign araddr            = araddr_q;
    assign arlen             = 8'd0;
    assign arsize            = {1'b0, size_q};
    assign arburst           = 2'b01;
    assign rready            = (cnt != 2'd0);
    assign inst_sram_data_ok = consume;
    assign inst_sram_rdata   = rdata;
    assign rd_err            = rd_err_q;

    // Slave-side protocol expectations for the single-ID, single-beat traffic we generate.
    rid_matches: assert property (@(posedge clk) disable iff (reset)
        consume |-> (rid == AXI_ID));
    rlast_single: assert property (@(posedge clk) disable iff (reset)
        consume |-> rlast);
    cnt_bounded: assert property (@(posedge clk) disable iff (reset)
        cnt <= CNT_MAX);

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Bench for inst_axi_rd_bridge: per-cycle vector table plus a data scoreboard.
module tb_inst_axi_rd_bridge;

    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        rd_err;

    inst_axi_rd_bridge #(
        .MAX_OUTSTANDING(2),
        .AXI_ID         (4'h0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_wr     (inst_sram_wr),
        .inst_sram_size   (inst_sram_size),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata  (inst_sram_rdata),
        .arid             (arid),
        .araddr           (araddr),
        .arlen            (arlen),
        .arsize           (arsize),
        .arburst          (arburst),
        .arvalid          (arvalid),
        .arready          (arready),
        .rid              (rid),
        .rdata            (rdata),
        .rresp            (rresp),
        .rlast            (rlast),
        .rvalid           (rvalid),
        .rready           (rready),
        .rd_err           (rd_err)
    );

    typedef struct {
        logic        rst;
        logic        req;
        logic [1:0]  size;
        logic [31:0] addr;
        logic        ar_rdy;
        logic        r_vld;
        logic [1:0]  r_resp;
        logic        e_addr_ok;
        logic        e_arvalid;
        logic [31:0] e_araddr;
        logic [2:0]  e_arsize;
        logic        e_rready;
        logic        e_data_ok;
        logic        e_rd_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] arQ[$];
    logic [31:0] expQ[$];
    int          checks;
    int          failures;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave memory contents: the boot word at the reset vector, a pattern elsewhere.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h1C000000) return 32'h02800C0C;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic addVec(input logic rst, input logic req, input logic [1:0] size,
                          input logic [31:0] addr, input logic ar_rdy, input logic r_vld,
                          input logic [1:0] r_resp, input logic e_aok, input logic e_arv,
                          input logic [31:0] e_araddr, input logic [2:0] e_arsize,
                          input logic e_rrdy, input logic e_dok, input logic e_err);
        vec_t v;
        v.rst = rst; v.req = req; v.size = size; v.addr = addr;
        v.ar_rdy = ar_rdy; v.r_vld = r_vld; v.r_resp = r_resp;
        v.e_addr_ok = e_aok; v.e_arvalid = e_arv; v.e_araddr = e_araddr;
        v.e_arsize = e_arsize; v.e_rready = e_rrdy; v.e_data_ok = e_dok; v.e_rd_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic checkEq(input string name, input int idx, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL v%0d %s: got %h, expected %h", idx, name, act, exp);
        end
    endtask

    // Compare the current cycle's outputs, then advance the slave and scoreboard models.
    task automatic checkOutput(input vec_t v, input int idx);
        checkEq("addr_ok", idx, 32'(inst_sram_addr_ok), 32'(v.e_addr_ok));
        checkEq("arvalid", idx, 32'(arvalid), 32'(v.e_arvalid));
        checkEq("araddr", idx, araddr, v.e_araddr);
        checkEq("arsize", idx, 32'(arsize), 32'(v.e_arsize));
        checkEq("rready", idx, 32'(rready), 32'(v.e_rready));
        checkEq("data_ok", idx, 32'(inst_sram_data_ok), 32'(v.e_data_ok));
        checkEq("rd_err", idx, 32'(rd_err), 32'(v.e_rd_err));
        if (inst_sram_data_ok) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL v%0d rdata: data_ok with no read pending, got %h", idx, inst_sram_rdata);
            end else begin
                checkEq("rdata", idx, inst_sram_rdata, expQ.pop_front());
            end
        end
        if (arvalid && arready) arQ.push_back(araddr);
        if (rvalid && rready && (arQ.size() != 0)) void'(arQ.pop_front());
        if (v.req && v.e_addr_ok) expQ.push_back(mem(v.addr));
        if (v.rst) begin
            arQ.delete();
            expQ.delete();
        end
    endtask

    // Drive one vector mid-cycle; the slave returns data for the oldest handshaken address.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        reset          = v.rst;
        inst_sram_req  = v.req;
        inst_sram_size = v.size;
        inst_sram_addr = v.addr;
        arready        = v.ar_rdy;
        rvalid         = v.r_vld;
        rresp          = v.r_resp;
        rdata          = (arQ.size() != 0) ? mem(arQ[0]) : 32'hDEADBEEF;
        #1;
        checkOutput(v, idx);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        inst_sram_req = 1'b0;
        inst_sram_wr = 1'b0;
        inst_sram_size = 2'b10;
        inst_sram_addr = 32'h0;
        arready = 1'b0;
        rid = 4'h0;
        rdata = 32'h0;
        rresp = 2'b00;
        rlast = 1'b1;
        rvalid = 1'b0;

        // rst req size addr ar rv resp | aok arv araddr arsize rrdy dok err
        // Single fetch at the reset vector.
        addVec(0,0,2,32'h0,        0,0,0, 0,0,32'h0,        3'd0,0,0,0);
        addVec(0,1,2,32'h1C000000, 0,0,0, 1,0,32'h0,        3'd0,0,0,0);
        addVec(0,0,2,32'h0,        1,0,0, 0,1,32'h1C000000, 3'd2,1,0,0);
        addVec(0,0,2,32'h0,        0,1,0, 0,0,32'h1C000000, 3'd2,1,1,0);
        addVec(0,0,2,32'h0,        0,0,0, 0,0,32'h1C000000, 3'd2,0,0,0);
        // AR backpressure while the fetch side wiggles req, addr and size.
        addVec(0,1,2,32'h1C000010, 0,0,0, 1,0,32'h1C000000, 3'd2,0,0,0);
        addVec(0,0,1,32'h1C000020, 0,0,0, 0,1,32'h1C000010, 3'd2,1,0,0);
        addVec(0,1,1,32'h1C000030, 0,0,0, 0,1,32'h1C000010, 3'd2,1,0,0);
        addVec(0,0,1,32'h1C000040, 0,0,0, 0,1,32'h1C000010, 3'd2,1,0,0);
        addVec(0,1,1,32'h1C000050, 0,0,0, 0,1,32'h1C000010, 3'd2,1,0,0);
        addVec(0,1,3,32'h1C000060, 0,0,0, 0,1,32'h1C000010, 3'd2,1,0,0);
        addVec(0,0,2,32'h0,        1,0,0, 0,1,32'h1C000010, 3'd2,1,0,0);
        addVec(0,0,2,32'h0,        1,0,0, 0,0,32'h1C000010, 3'd2,1,0,0);
        addVec(0,0,2,32'h0,        0,1,0, 0,0,32'h1C000010, 3'd2,1,1,0);
        // Outstanding limit of two, then one return frees a slot.
        addVec(0,1,2,32'h1C000100, 1,0,0, 1,0,32'h1C000010, 3'd2,0,0,0);
        addVec(0,1,2,32'h1C000104, 1,0,0, 0,1,32'h1C000100, 3'd2,1,0,0);
        addVec(0,1,2,32'h1C000104, 1,0,0, 1,0,32'h1C000100, 3'd2,1,0,0);
        addVec(0,1,2,32'h1C000108, 1,0,0, 0,1,32'h1C000104, 3'd2,1,0,0);
        addVec(0,1,2,32'h1C000108, 1,0,0, 0,0,32'h1C000104, 3'd2,1,0,0);
        addVec(0,1,2,32'h1C000108, 1,0,0, 0,0,32'h1C000104, 3'd2,1,0,0);
        addVec(0,1,2,32'h1C000108, 1,1,0, 0,0,32'h1C000104, 3'd2,1,1,0);
        addVec(0,1,2,32'h1C000108, 1,0,0, 1,0,32'h1C000104, 3'd2,1,0,0);
        addVec(0,0,2,32'h0,        1,0,0, 0,1,32'h1C000108, 3'd2,1,0,0);
        addVec(0,0,2,32'h0,        0,1,0, 0,0,32'h1C000108, 3'd2,1,1,0);
        // Accept and return in the same cycle at one outstanding, three ordered reads.
        addVec(0,1,2,32'h1C000000, 0,1,0, 1,0,32'h1C000108, 3'd2,1,1,0);
        addVec(0,1,2,32'h1C000004, 1,0,0, 0,1,32'h1C000000, 3'd2,1,0,0);
        addVec(0,1,2,32'h1C000004, 1,1,0, 1,0,32'h1C000000, 3'd2,1,1,0);
        addVec(0,1,2,32'h1C000008, 1,0,0, 0,1,32'h1C000004, 3'd2,1,0,0);
        addVec(0,1,2,32'h1C000008, 1,1,0, 1,0,32'h1C000004, 3'd2,1,1,0);
        addVec(0,0,2,32'h0,        1,0,0, 0,1,32'h1C000008, 3'd2,1,0,0);
        addVec(0,0,2,32'h0,        0,1,0, 0,0,32'h1C000008, 3'd2,1,1,0);
        addVec(0,0,2,32'h0,        0,0,0, 0,0,32'h1C000008, 3'd2,0,0,0);
        // SLVERR on the second beat: data still delivered, error flag sticky.
        addVec(0,1,2,32'h1C000200, 1,0,0, 1,0,32'h1C000008, 3'd2,0,0,0);
        addVec(0,1,2,32'h1C000204, 1,0,0, 0,1,32'h1C000200, 3'd2,1,0,0);
        addVec(0,1,2,32'h1C000204, 1,1,0, 1,0,32'h1C000200, 3'd2,1,1,0);
        addVec(0,0,2,32'h0,        1,0,0, 0,1,32'h1C000204, 3'd2,1,0,0);
        addVec(0,0,2,32'h0,        0,1,2, 0,0,32'h1C000204, 3'd2,1,1,0);
        addVec(0,0,2,32'h0,        0,0,0, 0,0,32'h1C000204, 3'd2,0,0,1);
        addVec(0,1,2,32'h1C000208, 1,0,0, 1,0,32'h1C000204, 3'd2,0,0,1);
        addVec(0,0,2,32'h0,        1,0,0, 0,1,32'h1C000208, 3'd2,1,0,1);
        addVec(0,0,2,32'h0,        0,1,0, 0,0,32'h1C000208, 3'd2,1,1,1);
        addVec(0,0,2,32'h0,        0,0,0, 0,0,32'h1C000208, 3'd2,0,0,1);
        // Reset while AR is pending with two outstanding, then spurious beats.
        addVec(0,1,2,32'h1C000300, 1,0,0, 1,0,32'h1C000208, 3'd2,0,0,1);
        addVec(0,1,2,32'h1C000304, 1,0,0, 0,1,32'h1C000300, 3'd2,1,0,1);
        addVec(0,1,2,32'h1C000304, 0,0,0, 1,0,32'h1C000300, 3'd2,1,0,1);
        addVec(1,0,2,32'h0,        0,0,0, 0,1,32'h1C000304, 3'd2,1,0,1);
        addVec(0,0,2,32'h0,        0,1,0, 0,0,32'h0,        3'd0,0,0,0);
        addVec(0,0,2,32'h0,        0,1,0, 0,0,32'h0,        3'd0,0,0,0);
        addVec(0,0,2,32'h0,        0,0,0, 0,0,32'h0,        3'd0,0,0,0);

        repeat (2) @(posedge clk);

        @(negedge clk);
        checkEq("arid", -1, 32'(arid), 32'h0);
        checkEq("arlen", -1, 32'(arlen), 32'h0);
        checkEq("arburst", -1, 32'(arburst), 32'h1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
        end

        checkEq("scoreboard_left", -1, 32'(expQ.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
